i2c_canvas_poller: RTL and testbench



---
 rtl/i2c_canvas_poller.sv | 189 ++++++++++++++++++
 tb/tb_i2c_canvas_poller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_canvas_poller.sv
// I2C master that reads the three-byte Tiny Canvas report (x, y, status) per start pulse.
// Optional slave clock stretching is compiled in with `define POLLER_STRETCH_EN.
module i2c_canvas_poller #(
    parameter logic [6:0]  I2C_ADDR = 7'b1100100,
    parameter int unsigned CLK_DIV  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [7:0] status_out,
    input  logic       scl_in,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_oe
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_RDATA, S_MACK, S_STOP
    } state_t;

    localparam logic [7:0] ADDR_BYTE = {I2C_ADDR, 1'b1};
    localparam logic [7:0] CNT_LAST  = 8'(CLK_DIV - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_phase;
    logic [2:0] r_bit;
    logic [1:0] r_byte;
    logic       r_sample, r_nack;
    logic [7:0] r_shift, r_d0, r_d1;
    logic       r_busy, r_done, r_nack_err, r_scl_oe, r_sda_oe;
    logic [7:0] r_x, r_y, r_s;

    logic       w_stall, w_tick, w_slot_end, w_accept, w_sample_pt;
    state_t     w_nxt_state;
    logic [7:0] w_nxt_cnt;
    logic [1:0] w_nxt_phase;
    logic [2:0] w_nxt_bit;
    logic [1:0] w_nxt_byte;
    logic [1:0] w_drive;

`ifdef POLLER_STRETCH_EN
    // A slave holding SCL low after release freezes the slot at the start of q2.
    assign w_stall = (r_state != S_IDLE) && (r_phase == 2'd2) && (r_cnt == 8'd0) && !scl_in;
`else
    logic w_unused_scl;
    assign w_unused_scl = scl_in;
    assign w_stall      = 1'b0;
`endif

    assign w_tick      = (r_cnt == CNT_LAST) && !w_stall;
    assign w_slot_end  = w_tick && (r_phase == 2'd3);
    assign w_accept    = (r_state == S_IDLE) && start && !r_done;
    assign w_sample_pt = (r_state != S_IDLE) && (r_phase == 2'd3) && (r_cnt == 8'd0);

    // Returns {scl_oe, sda_oe} for a given slot position; 1 means pull low.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] ph,
                                             input logic [2:0] bi, input logic [1:0] by);
        logic scl_low;
        scl_low = (ph < 2'd2);
        case (st)
            S_START: bus_drive = {1'b0, ph >= 2'd2};
            S_ADDR:  bus_drive = {scl_low, ~ADDR_BYTE[bi]};
            S_AACK:  bus_drive = {scl_low, 1'b0};
            S_RDATA: bus_drive = {scl_low, 1'b0};
            S_MACK:  bus_drive = {scl_low, by != 2'd2};
            S_STOP:  bus_drive = {ph == 2'd0, ph < 2'd2};
            default: bus_drive = 2'b00;
        endcase
    endfunction

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_bit   = r_bit;
        w_nxt_byte  = r_byte;
        w_nxt_cnt   = w_stall ? r_cnt : r_cnt + 8'd1;
        if (r_state == S_IDLE) begin
            w_nxt_cnt   = 8'd0;
            w_nxt_phase = 2'd0;
            if (w_accept) w_nxt_state = S_START;
        end else if (w_tick) begin
            w_nxt_cnt   = 8'd0;
            w_nxt_phase = r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                case (r_state)
                    S_START: begin
                        w_nxt_state = S_ADDR;
                        w_nxt_bit   = 3'd7;
                    end
                    S_ADDR: begin
                        if (r_bit == 3'd0) w_nxt_state = S_AACK;
                        else               w_nxt_bit   = r_bit - 3'd1;
                    end
                    S_AACK: begin
                        w_nxt_state = r_sample ? S_STOP : S_RDATA;
                        w_nxt_bit   = 3'd7;
                        w_nxt_byte  = 2'd0;
                    end
                    S_RDATA: begin
                        if (r_bit == 3'd0) w_nxt_state = S_MACK;
                        else               w_nxt_bit   = r_bit - 3'd1;
                    end
                    S_MACK: begin
                        if (r_byte == 2'd2) begin
                            w_nxt_state = S_STOP;
                        end else begin
                            w_nxt_state = S_RDATA;
                            w_nxt_bit   = 3'd7;
                            w_nxt_byte  = r_byte + 2'd1;
                        end
                    end
                    default: w_nxt_state = S_IDLE;
                endcase
            end
        end
        w_drive = bus_drive(w_nxt_state, w_nxt_phase, w_nxt_bit, w_nxt_byte);
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_phase    <= 2'd0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_sample   <= 1'b0;
            r_nack     <= 1'b0;
            r_shift    <= 8'd0;
            r_d0       <= 8'd0;
            r_d1       <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack_err <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_x        <= 8'd0;
            r_y        <= 8'd0;
            r_s        <= 8'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_phase  <= w_nxt_phase;
            r_bit    <= w_nxt_bit;
            r_byte   <= w_nxt_byte;
            r_scl_oe <= w_drive[1];
            r_sda_oe <= w_drive[0];
            r_busy   <= (w_nxt_state != S_IDLE);
            r_done   <= w_slot_end && (r_state == S_STOP);

            if (w_accept) r_nack <= 1'b0;
            if (w_sample_pt) begin
                r_sample <= sda_in;
                if (r_state == S_RDATA) r_shift <= {r_shift[6:0], sda_in};
            end
            if (w_slot_end && (r_state == S_AACK) && r_sample) r_nack <= 1'b1;
            if (w_slot_end && (r_state == S_MACK)) begin
                if (r_byte == 2'd0) r_d0 <= r_shift;
                if (r_byte == 2'd1) r_d1 <= r_shift;
            end
            // Byte 2 is still in the shifter at STOP; publish all three together.
            if (w_slot_end && (r_state == S_STOP)) begin
                r_nack_err <= r_nack;
                if (!r_nack) begin
                    r_x <= r_d0;
                    r_y <= r_d1;
                    r_s <= r_shift;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign nack_err   = r_nack_err;
    assign x_out      = r_x;
    assign y_out      = r_y;
    assign status_out = r_s;
    assign scl_oe     = r_scl_oe;
    assign sda_oe     = r_sda_oe;

endmodule

// File: tb/tb_i2c_canvas_poller.sv
// Bench for i2c_canvas_poller: bus-level slave model, protocol monitor and result scoreboard.
// With POLLER_STRETCH_EN defined it also exercises slave clock stretching.
module tb_i2c_canvas_poller;

    localparam int Q     = 25;
    localparam int LIMIT = 200 * Q;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, nack_err;
    logic [7:0] x_out, y_out, status_out;
    logic       scl_in, scl_oe, sda_in, sda_oe;
    logic       slave_sda_oe, slave_scl_hold;

    assign scl_in = ~(scl_oe | slave_scl_hold);
    assign sda_in = ~(sda_oe | slave_sda_oe);

    i2c_canvas_poller #(.I2C_ADDR(7'h64), .CLK_DIV(Q)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .nack_err(nack_err), .x_out(x_out), .y_out(y_out), .status_out(status_out),
        .scl_in(scl_in), .scl_oe(scl_oe), .sda_in(sda_in), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave and bus monitor state, written only by the monitor process.
    bit         present;
    bit         stretch_en;
    logic [7:0] tx [3];
    int         fall_cnt, hi_changes, done_cnt, stretch_k;
    logic       prev_scl, prev_sda, slave_acked;
    logic [7:0] rx_addr;
    logic [2:0] mack_bits;

    // Slot n after START: 1..8 address, 9 ack, then 9 slots (8 data + master ack) per byte.
    function automatic logic slave_drive(input int n);
        int k;
        if (n == 9) return present && (rx_addr == 8'hC9);
        if (n < 10 || n > 35 || !slave_acked) return 1'b0;
        k = n - 10;
        if (k % 9 == 8) return 1'b0;
        return ~tx[k / 9][7 - (k % 9)];
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            slave_sda_oe   <= 1'b0;
            slave_scl_hold <= 1'b0;
            slave_acked    <= 1'b0;
            fall_cnt       <= 0;
            stretch_k      <= 0;
            prev_scl       <= 1'b1;
            prev_sda       <= 1'b1;
        end else begin
            prev_scl <= scl_in;
            prev_sda <= sda_in;
            if (scl_in && prev_scl && (sda_in != prev_sda)) begin
                hi_changes <= hi_changes + 1;
                if (!sda_in) begin
                    fall_cnt     <= 0;
                    rx_addr      <= 8'd0;
                    mack_bits    <= 3'd0;
                    slave_acked  <= 1'b0;
                    slave_sda_oe <= 1'b0;
                end
            end else if (scl_in && !prev_scl) begin
                if (fall_cnt >= 1 && fall_cnt <= 8) rx_addr <= {rx_addr[6:0], sda_in};
                if (fall_cnt == 18 || fall_cnt == 27 || fall_cnt == 36)
                    mack_bits <= {mack_bits[1:0], sda_in};
            end else if (!scl_in && prev_scl) begin
                fall_cnt     <= fall_cnt + 1;
                slave_sda_oe <= slave_drive(fall_cnt + 1);
                if (fall_cnt + 1 == 9) slave_acked <= present && (rx_addr == 8'hC9);
            end
`ifdef POLLER_STRETCH_EN
            // Hold SCL low for exactly the 50 clock edges that start at the AACK slot's q2.
            if (!scl_in && prev_scl && (fall_cnt + 1 == 9) && stretch_en) stretch_k <= 1;
            else if (stretch_k >= 2 * Q + 49) stretch_k <= 0;
            else if (stretch_k != 0) stretch_k <= stretch_k + 1;
            slave_scl_hold <= (stretch_k >= 2 * Q - 1) && (stretch_k < 2 * Q + 49);
`endif
        end
    end

    logic [7:0] exp_x = 8'd0, exp_y = 8'd0, exp_s = 8'd0;

    // One read transaction; the reference outcome comes from the slave's configuration.
    task automatic run_txn(input string tag, input bit spam, input int extra);
        int lat, hi_base, done_base;
        bit ok;
        hi_base   = hi_changes;
        done_base = done_cnt;
        ok        = present;
        start = 1'b1;
        @(negedge clk);
        start = spam;
        lat = 1;
        check({tag, "_busy_rise"}, busy, 1'b1);
        while (!done && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (!spam) start = 1'b0;
        check({tag, "_latency"}, lat, (ok ? 152 * Q : 44 * Q) + 1 + extra);
        check({tag, "_busy_fall"}, busy, 1'b0);
        check({tag, "_nack"}, nack_err, !ok);
        if (ok) begin
            exp_x = tx[0];
            exp_y = tx[1];
            exp_s = tx[2];
            check({tag, "_mack"}, mack_bits, 3'b001);
        end
        check({tag, "_x"}, x_out, exp_x);
        check({tag, "_y"}, y_out, exp_y);
        check({tag, "_s"}, status_out, exp_s);
        check({tag, "_addr"}, rx_addr, 8'hC9);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_done_count"}, done_cnt - done_base, 1);
        check({tag, "_sda_hi_changes"}, hi_changes - hi_base, 2);
        check({tag, "_bus_released"}, {scl_oe, sda_oe}, 2'b00);
    endtask

    initial begin
        int wait_cnt, done_base;
        rst = 1'b1;
        start = 1'b0;
        present = 1'b1;
        stretch_en = 1'b0;
        hi_changes = 0;
        done_cnt = 0;
        rx_addr = 8'd0;
        mack_bits = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_nack", nack_err, 1'b0);
        check("reset_data", {x_out, y_out, status_out}, 24'd0);
        check("reset_bus", {scl_oe, sda_oe}, 2'b00);

        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'hA5;
        run_txn("directed", 1'b0, 0);

        for (int i = 0; i < 3; i++) begin
            tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
            run_txn($sformatf("rand%0d", i), (i == 1), 0);
        end

        present = 1'b0;
        tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        run_txn("noslave", 1'b0, 0);
        present = 1'b1;
        tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        run_txn("recover", 1'b0, 0);

        // Reset in the middle of byte 1.
        tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        done_base = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cnt = 0;
        while (fall_cnt < 21 && wait_cnt < LIMIT) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("midrst_reached_byte1", fall_cnt >= 21, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_bus", {scl_oe, sda_oe}, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", {x_out, y_out, status_out, nack_err}, 25'd0);
        exp_x = 8'd0; exp_y = 8'd0; exp_s = 8'd0;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_cnt - done_base, 0);
        tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        run_txn("after_rst", 1'b0, 0);

`ifdef POLLER_STRETCH_EN
        stretch_en = 1'b1;
        tx[0] = 8'($urandom); tx[1] = 8'($urandom); tx[2] = 8'($urandom);
        run_txn("stretch", 1'b0, 50);
        stretch_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
